// File: rtl/wasm_leb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wasm_leb_pkg
// Brief    : Shared types, limits and helpers for the LEB128 immediate decoder.
// Revision : 1.0 - initial release
// ============================================================================
package wasm_leb_pkg;

    // Immediate flavour requested by the execute stage
    typedef enum logic [1:0] {
        MODE_U32 = 2'd0,
        MODE_S32 = 2'd1,
        MODE_U64 = 2'd2,
        MODE_S64 = 2'd3
    } leb_mode_t;

    // Trap-compatible decode status
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_OVERLONG    = 2'd1,
        ERR_UNUSED_BITS = 2'd2,
        ERR_FETCH       = 2'd3
    } leb_err_t;

    // Decoder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_FINISH = 2'd2
    } leb_state_t;

    localparam int unsigned MAX_BYTES32 = 5;
    localparam int unsigned MAX_BYTES64 = 10;

    // Signed modes have the low mode bit set
    function automatic logic is_signed(leb_mode_t m);
        return m[0];
    endfunction

    // Longest legal encoding for the given mode
    function automatic logic [3:0] max_len(leb_mode_t m);
        return m[1] ? 4'(MAX_BYTES64) : 4'(MAX_BYTES32);
    endfunction

endpackage : wasm_leb_pkg
`default_nettype wire

// File: rtl/leb_final_check.sv
`default_nettype none
// ============================================================================
// Module   : leb_final_check
// Brief    : Unused-bit check on the byte occupying the last legal position.
//            Purely combinational; a byte in any other position passes.
// Revision : 1.0 - initial release
// ============================================================================
module leb_final_check
    import wasm_leb_pkg::*;
(
    input  leb_mode_t  i_mode,
    input  logic [3:0] i_count,   // 1-based position of i_byte in the encoding
    input  logic [7:0] i_byte,
    output leb_err_t   o_err
);

    // Only a terminating byte in the final position can carry excess bits;
    // a continuation byte there is reported as overlong by the caller.
    always_comb begin
        o_err = ERR_NONE;
        if ((i_count == max_len(i_mode)) && !i_byte[7]) begin
            unique case (i_mode)
                MODE_U32: if (i_byte[6:4] != 3'b000) o_err = ERR_UNUSED_BITS;
                MODE_S32: if ((i_byte[6:3] != 4'h0) && (i_byte[6:3] != 4'hF))
                              o_err = ERR_UNUSED_BITS;
                MODE_U64: if (i_byte[6:1] != 6'h00) o_err = ERR_UNUSED_BITS;
                MODE_S64: if ((i_byte[6:0] != 7'h00) && (i_byte[6:0] != 7'h7F))
                              o_err = ERR_UNUSED_BITS;
                default:  o_err = ERR_NONE;
            endcase
        end
    end

endmodule : leb_final_check
`default_nettype wire

// File: rtl/leb128_decoder.sv
`default_nettype none
// ============================================================================
// Module   : leb128_decoder
// Brief    : Byte-serial LEB128 immediate decoder (U32/S32/U64/S64) with
//            valid/ready input, 64-bit result, byte length and error code.
// Revision : 1.0 - initial release
// ============================================================================
module leb128_decoder #(
    parameter int DW          = 64,
    parameter int MAX_BYTES64 = 10,
    parameter int MAX_BYTES32 = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic          in_error,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] value,
    output logic [3:0]    length,
    output logic [1:0]    error
);
    import wasm_leb_pkg::*;

    // Room for ten full 7-bit groups; the excess above DW is dropped at output
    localparam int c_ACC_W = 7 * MAX_BYTES64;

    leb_state_t         r_state;
    leb_mode_t          r_mode;
    logic [c_ACC_W-1:0] r_acc;
    logic [3:0]         r_count;
    logic               r_done;
    logic [DW-1:0]      r_value;
    logic [3:0]         r_length;
    leb_err_t           r_error;

    logic [3:0]         w_num;
    logic [6:0]         w_shamt;
    logic [6:0]         w_nbits;
    logic [c_ACC_W-1:0] w_acc_next;
    logic [3:0]         w_max;
    logic               w_last_pos;
    logic               w_term;
    leb_err_t           w_fin_err;
    leb_err_t           w_err;
    logic [DW-1:0]      w_ext;
    logic [DW-1:0]      w_val;

    leb_final_check u_final_check (
        .i_mode  (r_mode),
        .i_count (w_num),
        .i_byte  (in_byte),
        .o_err   (w_fin_err)
    );

    // Datapath for the byte presented this cycle: accumulate, classify, extend
    always_comb begin
        w_num      = r_count + 4'd1;
        w_shamt    = 7'(r_count) * 7'd7;
        w_nbits    = 7'(w_num) * 7'd7;
        w_acc_next = r_acc | (c_ACC_W'(in_byte[6:0]) << w_shamt);
        w_max      = r_mode[1] ? 4'(MAX_BYTES64) : 4'(MAX_BYTES32);
        w_last_pos = (w_num == w_max);
        w_term     = in_error || !in_byte[7] || w_last_pos;

        if (in_error)
            w_err = ERR_FETCH;
        else if (w_last_pos && in_byte[7])
            w_err = ERR_OVERLONG;
        else
            w_err = w_fin_err;

        w_ext = w_acc_next[DW-1:0];
        if (is_signed(r_mode) && in_byte[6] && (w_nbits < 7'(DW)))
            w_ext = w_ext | ({DW{1'b1}} << w_nbits);

        unique case (r_mode)
            MODE_U32: w_val = {{(DW-32){1'b0}}, w_ext[31:0]};
            MODE_S32: w_val = {{(DW-32){w_ext[31]}}, w_ext[31:0]};
            default:  w_val = w_ext;
        endcase

        if (w_err != ERR_NONE)
            w_val = '0;
    end

    // Control FSM with registered result outputs; results land on the
    // accepting edge of the terminating byte so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_U32;
            r_acc    <= '0;
            r_count  <= 4'd0;
            r_done   <= 1'b0;
            r_value  <= '0;
            r_length <= 4'd0;
            r_error  <= ERR_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= ST_DECODE;
                        r_mode   <= leb_mode_t'(mode);
                        r_acc    <= '0;
                        r_count  <= 4'd0;
                        r_value  <= '0;
                        r_length <= 4'd0;
                        r_error  <= ERR_NONE;
                    end
                end
                ST_DECODE: begin
                    if (in_valid) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_num;
                        if (w_term) begin
                            r_state  <= ST_FINISH;
                            r_done   <= 1'b1;
                            r_value  <= w_val;
                            r_length <= w_num;
                            r_error  <= w_err;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_DECODE);
    assign busy     = (r_state == ST_DECODE);
    assign done     = r_done;
    assign value    = r_value;
    assign length   = r_length;
    assign error    = r_error;

endmodule : leb128_decoder
`default_nettype wire

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder between the fetch path (genrom byte window) and the core's execute stage.
- Consumes one instruction-stream byte per cycle over a valid/ready handshake and accumulates unsigned or signed 32/64-bit immediates, as used by i32.const, i64.const, br, local.get and similar.
- Produces a 64-bit value, a byte length for the PC advance, and a trap-compatible error code.

Parameters:
- DW, 64, result width; fixed at 64, and 32-bit modes extend into it.
- MAX_BYTES64, 10, maximum encoded length for 64-bit modes.
- MAX_BYTES32, 5, maximum encoded length for 32-bit modes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a decode; sampled only in IDLE.
- mode  in  2  captured on start; values per leb_mode_t: U32=0, S32=1, U64=2, S64=3.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  next instruction-stream byte.
- in_error  in  1  fetch fault accompanying in_byte (from mem_error).
- in_ready  out  1  decoder accepts a byte this cycle.
- busy  out  1  high in DECODE.
- done  out  1  one-cycle pulse: value, length and error are valid.
- value  out  64  decoded value; U32 zero-extended, S32 sign-extended to 64.
- length  out  4  bytes consumed, 1..10.
- error  out  2  leb_err_t: NONE=0, OVERLONG=1, UNUSED_BITS=2, FETCH=3.

Behaviour:
- Reset values: state IDLE, in_ready=0, busy=0, done=0, value=0, length=0, error=NONE.
- Reset mid-decode abandons the decode immediately. No done is issued for it.
- States:
  - IDLE: start → DECODE; mode is latched; accumulator, shift and count are cleared.
  - DECODE: in_ready=1. A byte is accepted on in_valid && in_ready.
    - Payload bits [6:0] are ORed into the accumulator at offset 7*count.
    - count is incremented.
    - in_byte[7]=0 → FINISH. in_byte[7]=1 → stay in DECODE, or error if the limit is reached.
  - FINISH: single cycle. Applies sign extension, drives done=1, then returns to IDLE.
- start in DECODE or FINISH is ignored.
- Handshake:
  - in_ready is 0 outside DECODE.
  - Idle in_valid cycles stall decoding with no state change. in_byte is don't-care when in_valid=0.
- Latency: done asserts exactly 1 cycle after the terminating byte is accepted. N-byte immediate with no stalls → done at cycle N+1 after the start cycle.
- Outputs value, length and error hold after done until the next start is accepted. They are cleared to 0 in the cycle start is taken.
- Sign extension (signed modes): if terminating byte bit6=1 and 7*count < 64, set all bits ≥ 7*count. S32 then sign-extends from bit 31.
- Error rules. The first matching rule wins; the decoder goes to FINISH with done=1 and value=0. length equals the bytes accepted including the offending byte.
  - FETCH: in_error=1 on an accepted byte.
  - OVERLONG: byte number MAX_BYTES (per mode) has bit7=1.
  - UNUSED_BITS, checked on the final-position byte only:
    - U32 5th byte: bits[6:4] ≠ 0.
    - S32 5th byte: bits[6:3] not all 0 and not all 1.
    - U64 10th byte: bits[6:1] ≠ 0.
    - S64 10th byte: bits[6:0] not all 0 and not all 1.
- The accumulator is 70 bits internally; bits above 63 are discarded after the checks.

Decomposition:
- Package wasm_leb_pkg holds:
  - leb_mode_t enum.
  - leb_err_t enum.
  - MAX_BYTES32 and MAX_BYTES64 constants.
  - State enum {IDLE, DECODE, FINISH}.
  - function is_signed(mode).
  - function max_len(mode).
- One combinational sub-module, leb_final_check, takes mode, count and in_byte and returns leb_err_t. It isolates the unused-bit rules for separate unit testing.

Test Plan:
- U32, bytes E5 8E 26, no stalls → done 4 cycles after start, value=0x0000_0000_0009_8765 (624485), length=3, error=NONE.
- S32, bytes C0 BB 78 with in_valid=0 gaps between bytes → value=0xFFFF_FFFF_FFFE_1DC0 (−123456), length=3; in_ready is stable through the gaps.
- S64, byte 7F → value=0xFFFF_FFFF_FFFF_FFFF, length=1. U64, bytes FF×9 then 01 → value=0xFFFF_FFFF_FFFF_FFFF, length=10, error=NONE.
- U32, bytes 80 80 80 80 80 → error=OVERLONG, length=5, value=0. U32, bytes 80 80 80 80 10 → error=UNUSED_BITS.
- S32, 2nd byte with in_error=1 → error=FETCH, length=2. Next start with U32 byte 05 → value=5, error=NONE; the previous error is cleared on start.
- reset=1 after 2 bytes of a 3-byte decode → next cycle in_ready=0, done=0, value=0. A new start then decodes 2A → value=42.
